// File: rtl/ocp_nic_pwr_seq.sv
// OCP NIC 3.0 slot power sequencer: aux rail, main rail, PERST# release on the
// way up, the reverse on the way down, and an immediate shutdown on any PG fault.
module ocp_nic_pwr_seq #(
  parameter logic [15:0] PG_TIMEOUT   = 16'd10000,
  parameter logic [15:0] AUX_MAIN_DLY = 16'd5000,
  parameter logic [15:0] PERST_DLY    = 16'd2000,
  parameter logic [15:0] DN_DLY       = 16'd500
) (
  input  logic        clk_in,
  input  logic        iRst,
  input  logic        iPwr_req,
  input  logic        iAux_pg,
  input  logic        iMain_pg,
  input  logic        iDly_timeout,
  output logic        oDly_en,
  output logic [15:0] oDly_time,
  output logic        oAux_en,
  output logic        oMain_en,
  output logic        oPerst_n,
  output logic        oFault,
  output logic [3:0]  oState
);

  typedef enum logic [3:0] {
    ST_OFF      = 4'd0,
    ST_AUX_EN   = 4'd1,
    ST_AUX_DLY  = 4'd2,
    ST_MAIN_EN  = 4'd3,
    ST_MAIN_DLY = 4'd4,
    ST_ON       = 4'd5,
    ST_DN_PERST = 4'd6,
    ST_DN_MAIN  = 4'd7,
    ST_FAULT    = 4'd8
  } state_t;

  state_t      state_q, state_d;
  logic        dly_en_q, dly_en_d;
  logic [15:0] dly_time_q, dly_time_d;
  logic        aux_en_q, aux_en_d;
  logic        main_en_q, main_en_d;
  logic        perst_n_q, perst_n_d;
  logic        fault_q, fault_d;
  logic        tmo;
  logic        pg_lost;

  // Delay value loaded into the external timer for each state; 0 means untimed.
  function automatic logic [15:0] dly_for(input state_t s);
    logic [15:0] v;
    case (s)
      ST_AUX_EN, ST_MAIN_EN:   v = PG_TIMEOUT;
      ST_AUX_DLY:              v = AUX_MAIN_DLY;
      ST_MAIN_DLY:             v = PERST_DLY;
      ST_DN_PERST, ST_DN_MAIN: v = DN_DLY;
      default:                 v = 16'd0;
    endcase
    return v;
  endfunction

  function automatic logic is_timed(input state_t s);
    logic t;
    case (s)
      ST_AUX_EN, ST_AUX_DLY, ST_MAIN_EN, ST_MAIN_DLY,
      ST_DN_PERST, ST_DN_MAIN: t = 1'b1;
      default:                 t = 1'b0;
    endcase
    return t;
  endfunction

  // A timeout seen during the restart gap belongs to the previous state's delay.
  assign tmo = iDly_timeout & dly_en_q;

  // Next-state logic; PG loss overrides everything, then power-request drop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_AUX_DLY, ST_MAIN_EN:  pg_lost = ~iAux_pg;
      ST_MAIN_DLY, ST_ON:      pg_lost = ~iAux_pg | ~iMain_pg;
      default:                 pg_lost = 1'b0;
    endcase

    if (pg_lost) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (iPwr_req) state_d = ST_AUX_EN;
          else          state_d = ST_OFF;
        end
        ST_AUX_EN: begin
          if (!iPwr_req)    state_d = ST_OFF;
          else if (iAux_pg) state_d = ST_AUX_DLY;
          else if (tmo)     state_d = ST_FAULT;
          else              state_d = ST_AUX_EN;
        end
        ST_AUX_DLY: begin
          if (!iPwr_req) state_d = ST_OFF;
          else if (tmo)  state_d = ST_MAIN_EN;
          else           state_d = ST_AUX_DLY;
        end
        ST_MAIN_EN: begin
          if (!iPwr_req)     state_d = ST_DN_MAIN;
          else if (iMain_pg) state_d = ST_MAIN_DLY;
          else if (tmo)      state_d = ST_FAULT;
          else               state_d = ST_MAIN_EN;
        end
        ST_MAIN_DLY: begin
          if (!iPwr_req) state_d = ST_DN_MAIN;
          else if (tmo)  state_d = ST_ON;
          else           state_d = ST_MAIN_DLY;
        end
        ST_ON: begin
          if (!iPwr_req) state_d = ST_DN_PERST;
          else           state_d = ST_ON;
        end
        ST_DN_PERST: begin
          if (tmo) state_d = ST_DN_MAIN;
          else     state_d = ST_DN_PERST;
        end
        ST_DN_MAIN: begin
          if (tmo) state_d = ST_OFF;
          else     state_d = ST_DN_MAIN;
        end
        ST_FAULT: begin
          if (!iPwr_req) state_d = ST_FAULT == ST_FAULT ? ST_OFF : ST_FAULT;
          else           state_d = ST_FAULT;
        end
        default: state_d = ST_FAULT;
      endcase
    end
  end

  // Output decode from the next state so every output moves on the entering edge.
  always_comb begin
    dly_time_d = dly_for(state_d);
    dly_en_d   = (state_d == state_q) & is_timed(state_d);
    aux_en_d   = 1'b0;
    main_en_d  = 1'b0;
    perst_n_d  = 1'b0;
    fault_d    = 1'b0;
    case (state_d)
      ST_AUX_EN, ST_AUX_DLY: aux_en_d = 1'b1;
      ST_MAIN_EN, ST_MAIN_DLY, ST_DN_PERST: begin
        aux_en_d  = 1'b1;
        main_en_d = 1'b1;
      end
      ST_ON: begin
        aux_en_d  = 1'b1;
        main_en_d = 1'b1;
        perst_n_d = 1'b1;
      end
      ST_DN_MAIN: aux_en_d = 1'b1;
      ST_FAULT:   fault_d  = 1'b1;
      default: begin
        aux_en_d  = 1'b0;
        main_en_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset removes all power with no down-sequence.
  always_ff @(posedge clk_in or posedge iRst) begin
    if (iRst) begin
      state_q    <= ST_OFF;
      dly_en_q   <= 1'b0;
      dly_time_q <= 16'd0;
      aux_en_q   <= 1'b0;
      main_en_q  <= 1'b0;
      perst_n_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_en_q   <= dly_en_d;
      dly_time_q <= dly_time_d;
      aux_en_q   <= aux_en_d;
      main_en_q  <= main_en_d;
      perst_n_q  <= perst_n_d;
      fault_q    <= fault_d;
    end
  end

  assign oDly_en   = dly_en_q;
  assign oDly_time = dly_time_q;
  assign oAux_en   = aux_en_q;
  assign oMain_en  = main_en_q;
  assign oPerst_n  = perst_n_q;
  assign oFault    = fault_q;
  assign oState    = state_q;

endmodule

// File: tb/tb_ocp_nic_pwr_seq.sv
// Bench for ocp_nic_pwr_seq: a delay-timer and PG model drive the DUT, expected
// state entries are queued by the stimulus and checked by an independent monitor.
module tb_ocp_nic_pwr_seq;

  localparam logic [15:0] PGT = 16'd10;
  localparam logic [15:0] AMD = 16'd2;
  localparam logic [15:0] PD  = 16'd2;
  localparam logic [15:0] DD  = 16'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        aux_pg, main_pg, tmo;
  logic        dly_en, aux_en, main_en, perst_n, fault;
  logic [15:0] dly_time;
  logic [3:0]  state;

  ocp_nic_pwr_seq #(
    .PG_TIMEOUT(PGT), .AUX_MAIN_DLY(AMD), .PERST_DLY(PD), .DN_DLY(DD)
  ) dut (
    .clk_in(clk), .iRst(rst), .iPwr_req(req), .iAux_pg(aux_pg),
    .iMain_pg(main_pg), .iDly_timeout(tmo), .oDly_en(dly_en),
    .oDly_time(dly_time), .oAux_en(aux_en), .oMain_en(main_en),
    .oPerst_n(perst_n), .oFault(fault), .oState(state)
  );

  always #5 clk = ~clk;

  // Constant-mode delay timer: cleared while disabled, fires N+1 edges after enable.
  logic [15:0] tcnt = 16'd0;
  always @(posedge clk) begin
    if (!dly_en) tcnt <= 16'd0;
    else if (tcnt < dly_time) tcnt <= tcnt + 16'd1;
  end
  assign tmo = dly_en && (tcnt >= dly_time);

  // Rails report PG three cycles after enable unless the bench blocks them.
  logic [1:0] acnt = 2'd0, mcnt = 2'd0;
  logic aux_ok = 1'b1, main_ok = 1'b1;
  always @(posedge clk) begin
    acnt <= !aux_en ? 2'd0 : (acnt == 2'd3 ? 2'd3 : acnt + 2'd1);
    mcnt <= !main_en ? 2'd0 : (mcnt == 2'd3 ? 2'd3 : mcnt + 2'd1);
  end
  assign aux_pg  = aux_ok && (acnt == 2'd3);
  assign main_pg = main_ok && (mcnt == 2'd3);

  typedef struct packed {
    logic [3:0]  st;
    logic        aux;
    logic        main;
    logic        perst;
    logic        flt;
    logic [15:0] tm;
    logic [7:0]  dly;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;
  logic [3:0] prev = 4'd0;
  int   cyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic aux, input logic main,
                      input logic perst, input logic flt, input logic [15:0] tm,
                      input logic [7:0] dly);
    exp_t e;
    e.st = st; e.aux = aux; e.main = main; e.perst = perst;
    e.flt = flt; e.tm = tm; e.dly = dly;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idle: %0d entries still pending after %0d cycles", sb_q.size(), n);
      sb_q.delete();
    end
    #1;
  endtask

  task automatic power_up();
    push(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, PGT,   8'd0);
    push(4'd2, 1'b1, 1'b0, 1'b0, 1'b0, AMD,   8'd4);
    push(4'd3, 1'b1, 1'b1, 1'b0, 1'b0, PGT,   8'd4);
    push(4'd4, 1'b1, 1'b1, 1'b0, 1'b0, PD,    8'd4);
    push(4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 8'd4);
    req = 1'b1;
    wait_idle();
  endtask

  // Monitor: every state change pops the next expected entry and checks it.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      cyc++;
      if (state !== prev) begin
        if (sb_q.size() == 0) begin
          check("unexpected_state", {28'd0, state}, {28'd0, prev});
        end else begin
          e = sb_q.pop_front();
          check("state_entry",
                {7'd0, state, aux_en, main_en, perst_n, fault, dly_en, dly_time},
                {7'd0, e.st, e.aux, e.main, e.perst, e.flt, 1'b0, e.tm});
          if (e.dly != 8'd0) check("entry_delay", cyc, {24'd0, e.dly});
        end
        prev = state;
        cyc  = 0;
      end
    end
  end

  task automatic check_all_zero(input string nm);
    check(nm, {9'd0, state, dly_en, aux_en, main_en, perst_n, fault, dly_time}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst = 1'b0;
    mon_en = 1'b1;

    // Normal power-up then orderly power-down.
    power_up();
    push(4'd6, 1'b1, 1'b1, 1'b0, 1'b0, DD,    8'd2);
    push(4'd7, 1'b1, 1'b0, 1'b0, 1'b0, DD,    8'd5);
    push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd5);
    req = 1'b0;
    wait_idle();

    // Aux PG never arrives: FAULT after the PG timeout, cleared by dropping req.
    aux_ok = 1'b0;
    push(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, PGT,   8'd0);
    push(4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 8'd12);
    req = 1'b1;
    wait_idle();
    push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd2);
    req = 1'b0;
    wait_idle();
    aux_ok = 1'b1;

    // Main PG loss in ON.
    power_up();
    push(4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 8'd2);
    main_ok = 1'b0;
    wait_idle();
    push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd2);
    req = 1'b0;
    wait_idle();
    main_ok = 1'b1;

    // Request drop in MAIN_DLY goes straight to DN_MAIN.
    push(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, PGT,   8'd0);
    push(4'd2, 1'b1, 1'b0, 1'b0, 1'b0, AMD,   8'd4);
    push(4'd3, 1'b1, 1'b1, 1'b0, 1'b0, PGT,   8'd4);
    push(4'd4, 1'b1, 1'b1, 1'b0, 1'b0, PD,    8'd4);
    req = 1'b1;
    wait_idle();
    push(4'd7, 1'b1, 1'b0, 1'b0, 1'b0, DD,    8'd2);
    push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd5);
    req = 1'b0;
    wait_idle();

    // Request drop in AUX_DLY returns to OFF on the next edge.
    push(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, PGT,   8'd0);
    push(4'd2, 1'b1, 1'b0, 1'b0, 1'b0, AMD,   8'd4);
    req = 1'b1;
    wait_idle();
    push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd2);
    req = 1'b0;
    wait_idle();

    // Asynchronous reset while ON.
    power_up();
    push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
    #1 rst = 1'b1;
    #1 check_all_zero("async_reset");
    req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_idle();

    // Main PG drop together with request drop: PG loss wins.
    power_up();
    push(4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 8'd2);
    push(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd1);
    main_ok = 1'b0;
    req = 1'b0;
    wait_idle();
    main_ok = 1'b1;

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
